// File: rtl/ocp_slave_fsm.sv
// OCP slave with a small word-addressed memory, pipelined single-beat reads/writes and ERR for
// unsupported commands. Define OCP_SLAVE_SRMD_EN to add single-request multiple-data read bursts.
module ocp_slave_fsm #(
    parameter int MDATA_WIDTH    = 8,
    parameter int MADDR_WIDTH    = 64,
    parameter int MEM_DEPTH_LOG2 = 4
) (
    input  logic                   Clk,
    input  logic                   MReset_n,
    input  logic [2:0]             MCmd,
    input  logic [MADDR_WIDTH-1:0] MAddr,
    input  logic [MDATA_WIDTH-1:0] MData,
    input  logic [9:0]             MBurstLength,
    input  logic                   MBurstSingleReq,
    input  logic                   MReqLast,
    output logic                   SCmdAccept,
    output logic [1:0]             SResp,
    output logic [MDATA_WIDTH-1:0] SData,
    output logic                   SRespLast
);

    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;
    localparam logic [2:0] CMD_WRNP = 3'b101;

    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_DVA  = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b11;

`ifdef OCP_SLAVE_SRMD_EN
    typedef enum logic {ST_IDLE, ST_SRMD_RD} state_e;
`else
    typedef enum logic {ST_IDLE} state_e;
`endif

    state_e                    state_q, state_d;
    logic [1:0]                resp_q, resp_d;
    logic [MDATA_WIDTH-1:0]    data_q, data_d;
    logic                      last_q, last_d;
    logic [MDATA_WIDTH-1:0]    mem_q [DEPTH];
    logic                      mem_we;
    logic [MEM_DEPTH_LOG2-1:0] idx;
    logic                      unused_bits;

`ifdef OCP_SLAVE_SRMD_EN
    logic [MEM_DEPTH_LOG2-1:0] burst_addr_q, burst_addr_d;
    logic [9:0]                beat_cnt_q, beat_cnt_d;
`endif

    // Only the word-index bits select storage; everything else aliases onto it.
    assign idx = MAddr[MEM_DEPTH_LOG2+1:2];

`ifdef OCP_SLAVE_SRMD_EN
    assign unused_bits = ^{MAddr[MADDR_WIDTH-1:MEM_DEPTH_LOG2+2], MAddr[1:0]};
`else
    assign unused_bits = ^{MAddr[MADDR_WIDTH-1:MEM_DEPTH_LOG2+2], MAddr[1:0],
                           MBurstLength, MBurstSingleReq};
`endif

    assign SCmdAccept = (state_q == ST_IDLE) && (MCmd != CMD_IDLE) && MReset_n;

    assign SResp     = resp_q;
    assign SData     = data_q;
    assign SRespLast = last_q;

    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        resp_d  = RESP_NULL;
        data_d  = '0;
        last_d  = 1'b0;
        mem_we  = 1'b0;
`ifdef OCP_SLAVE_SRMD_EN
        burst_addr_d = burst_addr_q;
        beat_cnt_d   = beat_cnt_q;
`endif
        if (state_q == ST_IDLE) begin
            if (SCmdAccept) begin
                case (MCmd)
                    CMD_WR, CMD_WRNP: begin
`ifdef OCP_SLAVE_SRMD_EN
                        if (MBurstSingleReq) begin
                            resp_d = RESP_ERR;
                            last_d = 1'b1;
                        end else
`endif
                        begin
                            mem_we = 1'b1;
                            if (MCmd == CMD_WRNP) begin
                                resp_d = RESP_DVA;
                                last_d = MReqLast;
                            end
                        end
                    end
                    CMD_RD: begin
                        resp_d = RESP_DVA;
                        data_d = mem_q[idx];
                        last_d = MReqLast;
`ifdef OCP_SLAVE_SRMD_EN
                        // First beat leaves with the accept; the counter holds the beats still owed.
                        if (MBurstSingleReq) begin
                            state_d      = ST_SRMD_RD;
                            last_d       = (MBurstLength <= 10'd1);
                            burst_addr_d = idx + MEM_DEPTH_LOG2'(1);
                            beat_cnt_d   = (MBurstLength == 10'd0) ? 10'd0 : MBurstLength - 10'd1;
                        end
`endif
                    end
                    default: begin
                        resp_d = RESP_ERR;
                        last_d = 1'b1;
                    end
                endcase
            end
        end
`ifdef OCP_SLAVE_SRMD_EN
        else begin
            if (beat_cnt_q == 10'd0) begin
                state_d = ST_IDLE;
            end else begin
                resp_d       = RESP_DVA;
                data_d       = mem_q[burst_addr_q];
                last_d       = (beat_cnt_q == 10'd1);
                burst_addr_d = burst_addr_q + MEM_DEPTH_LOG2'(1);
                beat_cnt_d   = beat_cnt_q - 10'd1;
            end
        end
`endif
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch and not in the sensitivity list.
    always_ff @(posedge Clk) begin
        if (!MReset_n) begin
            state_q <= ST_IDLE;
            resp_q  <= RESP_NULL;
            data_q  <= '0;
            last_q  <= 1'b0;
`ifdef OCP_SLAVE_SRMD_EN
            burst_addr_q <= '0;
            beat_cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
            data_q  <= data_d;
            last_q  <= last_d;
`ifdef OCP_SLAVE_SRMD_EN
            burst_addr_q <= burst_addr_d;
            beat_cnt_q   <= beat_cnt_d;
`endif
        end
    end

    // NOTE: storage is deliberately left out of reset so its contents survive MReset_n.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[idx] <= MData;
        end
    end

endmodule

// File: tb/tb_ocp_slave_fsm.sv
// Scoreboard bench for ocp_slave_fsm: a transaction-level model predicts each response and the
// cycle it must appear in; a monitor compares every cycle against that queue.
module tb_ocp_slave_fsm;

    localparam logic [2:0] C_IDLE = 3'd0, C_WR = 3'd1, C_RD = 3'd2, C_RDEX = 3'd3;
    localparam logic [2:0] C_RDL  = 3'd4, C_WRNP = 3'd5, C_WRC = 3'd6, C_BCST = 3'd7;
    localparam logic [1:0] R_DVA = 2'b01, R_ERR = 2'b11;
`ifdef OCP_SLAVE_SRMD_EN
    localparam bit SRMD = 1'b1;
`else
    localparam bit SRMD = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        MReset_n;
    logic [2:0]  MCmd;
    logic [63:0] MAddr;
    logic [7:0]  MData;
    logic [9:0]  MBurstLength;
    logic        MBurstSingleReq;
    logic        MReqLast;
    logic        SCmdAccept;
    logic [1:0]  SResp;
    logic [7:0]  SData;
    logic        SRespLast;

    ocp_slave_fsm dut (
        .Clk(Clk), .MReset_n(MReset_n), .MCmd(MCmd), .MAddr(MAddr), .MData(MData),
        .MBurstLength(MBurstLength), .MBurstSingleReq(MBurstSingleReq), .MReqLast(MReqLast),
        .SCmdAccept(SCmdAccept), .SResp(SResp), .SData(SData), .SRespLast(SRespLast)
    );

    typedef struct {
        int         stamp;
        logic [1:0] resp;
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem [16];
    int         blk_until = 0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, want);
        end
    endtask

    function automatic void push(input int s, input logic [1:0] r, input logic [7:0] d, input logic l);
        exp_q.push_back('{stamp: s, resp: r, data: d, last: l});
    endfunction

    // Presents one command for the next rising edge and updates the model with its effect.
    task automatic drive(input logic [2:0] cmd, input logic [63:0] addr, input logic [7:0] data,
                         input logic [9:0] blen, input logic single, input logic last,
                         input logic rstn);
        int   e, idx, len;
        logic acc;
        @(negedge Clk);
        MCmd = cmd; MAddr = addr; MData = data; MBurstLength = blen;
        MBurstSingleReq = single; MReqLast = last; MReset_n = rstn;
        e   = cyc + 1;
        acc = rstn && (cmd != C_IDLE) && (e > blk_until);
        #1 check("accept", 32'(SCmdAccept), 32'(acc));
        if (!rstn) begin
            while (exp_q.size() > 0 && exp_q[exp_q.size()-1].stamp >= e) void'(exp_q.pop_back());
            blk_until = 0;
        end else if (acc) begin
            idx = int'(addr[5:2]);
            case (cmd)
                C_WR: begin
                    if (SRMD && single) push(e, R_ERR, 8'h00, 1'b1);
                    else ref_mem[idx] = data;
                end
                C_WRNP: begin
                    if (SRMD && single) push(e, R_ERR, 8'h00, 1'b1);
                    else begin
                        ref_mem[idx] = data;
                        push(e, R_DVA, 8'h00, last);
                    end
                end
                C_RD: begin
                    if (SRMD && single) begin
                        len = (blen == 10'd0) ? 1 : int'(blen);
                        for (int b = 0; b < len; b++)
                            push(e + b, R_DVA, ref_mem[(idx + b) % 16], b == len - 1);
                        blk_until = e + len;
                    end else begin
                        push(e, R_DVA, ref_mem[idx], last);
                    end
                end
                default: push(e, R_ERR, 8'h00, 1'b1);
            endcase
        end
    endtask

    initial begin
        exp_t ex;
        forever begin
            @(posedge Clk);
            #2;
            if (exp_q.size() > 0 && exp_q[0].stamp == cyc) begin
                ex = exp_q.pop_front();
                check("response", 32'({SResp, SData, SRespLast}), 32'({ex.resp, ex.data, ex.last}));
            end else begin
                check("no_response", 32'({SResp, SData, SRespLast}), 32'd0);
            end
        end
    end

    initial begin
        logic [2:0] cmd;
        MReset_n = 1'b0; MCmd = C_IDLE; MAddr = '0; MData = '0;
        MBurstLength = '0; MBurstSingleReq = 1'b0; MReqLast = 1'b0;
        repeat (3) drive(C_IDLE, '0, '0, '0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) drive(C_WR, 64'(i * 4), 8'($urandom), '0, 1'b0, 1'b0, 1'b1);

        // Write then read back the same word.
        drive(C_WR, 64'h4, 8'hFF, '0, 1'b0, 1'b0, 1'b1);
        drive(C_RD, 64'h4, '0, '0, 1'b0, 1'b1, 1'b1);

        // Four-request read burst over preloaded words 1..4.
        for (int i = 0; i < 4; i++) drive(C_WR, 64'(i * 4), 8'(i + 1), '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(C_RD, 64'(i * 4), '0, '0, 1'b0, i == 3, 1'b1);

        // Unsupported command leaves memory untouched.
        drive(C_RDEX, 64'h0, 8'hAA, '0, 1'b0, 1'b0, 1'b1);
        drive(C_RD, 64'h0, '0, '0, 1'b0, 1'b1, 1'b1);

        // Non-posted write, then read it back later; high address bits must alias.
        drive(C_WRNP, 64'h8, 8'h5A, '0, 1'b0, 1'b1, 1'b1);
        drive(C_IDLE, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        drive(C_RD, 64'hF000_0000_0000_0008, '0, '0, 1'b0, 1'b1, 1'b1);

`ifdef OCP_SLAVE_SRMD_EN
        // Single-request burst wrapping past the top index; commands during it are refused.
        drive(C_RD, 64'h38, '0, 10'd7, 1'b1, 1'b0, 1'b1);
        repeat (7) drive(C_RD, 64'($urandom), '0, '0, 1'b0, 1'b1, 1'b1);
        drive(C_RD, 64'h0, '0, 10'd0, 1'b1, 1'b0, 1'b1);
        drive(C_IDLE, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        drive(C_WR, 64'h10, 8'h33, '0, 1'b1, 1'b0, 1'b1);
        // Reset lands while the third beat of a seven-beat burst is on the bus.
        drive(C_RD, 64'h0, '0, 10'd7, 1'b1, 1'b0, 1'b1);
        repeat (2) drive(C_IDLE, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        drive(C_RD, 64'h4, '0, '0, 1'b0, 1'b1, 1'b0);
        drive(C_RD, 64'h4, '0, '0, 1'b0, 1'b1, 1'b1);
`else
        drive(C_RD, 64'h4, '0, 10'd7, 1'b1, 1'b0, 1'b1);
        drive(C_RD, 64'h8, '0, '0, 1'b0, 1'b1, 1'b0);
        drive(C_RD, 64'h8, '0, '0, 1'b0, 1'b1, 1'b1);
`endif

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    cmd = C_IDLE;
                2, 3, 9: cmd = C_WR;
                4, 5, 8: cmd = C_RD;
                6:       cmd = C_WRNP;
                default: case ($urandom_range(0, 3))
                    0: cmd = C_RDEX;
                    1: cmd = C_RDL;
                    2: cmd = C_WRC;
                    default: cmd = C_BCST;
                endcase
            endcase
            drive(cmd, {32'($urandom), 32'($urandom)}, 8'($urandom), 10'($urandom_range(0, 5)),
                  SRMD ? ($urandom_range(0, 3) == 0) : 1'($urandom), 1'($urandom),
                  $urandom_range(0, 39) != 0);
        end

        repeat (8) drive(C_IDLE, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        @(negedge Clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ocp_slave_fsm.md
OCP_SLAVE_FSM -- requirements
Module: ocp_slave_fsm

Interface
REQ-001 SHALL have parameter MDATA_WIDTH, default 8, data width of MData and SData.
REQ-002 SHALL have parameter MADDR_WIDTH, default 64, width of MAddr.
REQ-003 SHALL have parameter MEM_DEPTH_LOG2, default 4, log2 of the number of internal storage words.
REQ-004 SHALL have port Clk, input, 1, OCP clock; all logic is on the rising edge.
REQ-005 SHALL have port MReset_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port MCmd, input, 3, OCP command: IDLE=000, WR=001, RD=010, RDEX=011, RDL=100, WRNP=101, WRC=110, BCST=111.
REQ-007 SHALL have port MAddr, input, MADDR_WIDTH, byte address.
REQ-008 SHALL have port MData, input, MDATA_WIDTH, write data.
REQ-009 SHALL have port MBurstLength, input, 10, burst length in beats.
REQ-010 SHALL have port MBurstSingleReq, input, 1, single-request multiple-data burst flag.
REQ-011 SHALL have port MReqLast, input, 1, last request of a burst.
REQ-012 SHALL have port SCmdAccept, output, 1, command accepted this cycle.
REQ-013 SHALL have port SResp, output, 2, response code: NULL=00, DVA=01, FAIL=10, ERR=11.
REQ-014 SHALL have port SData, output, MDATA_WIDTH, read data.
REQ-015 SHALL have port SRespLast, output, 1, last response of a burst.

Function
REQ-016 SHALL use word index MAddr[MEM_DEPTH_LOG2+1:2]; all other address bits are ignored and out-of-range addresses wrap.
REQ-017 SHALL implement states IDLE and SRMD_RD.
REQ-018 SHALL drive SCmdAccept combinationally as (state==IDLE && MCmd!=IDLE && MReset_n).
REQ-019 SHALL treat a command as accepted on a rising edge where MCmd!=IDLE and SCmdAccept=1.
REQ-020 On an accepted WR, SHALL write MData to mem[index] at that edge and SHALL produce no response.
REQ-021 On an accepted WRNP, SHALL write the memory and drive SResp=DVA, SData=0 for exactly the next cycle.
REQ-022 On an accepted RD (multiple-request), SHALL drive SResp=DVA, SData=mem[index] and SRespLast=MReqLast for exactly the next cycle; latency is 1 cycle.
REQ-023 SHALL accept back-to-back commands with no bubble in IDLE; the response of request N SHALL coincide with the acceptance of request N+1.
REQ-024 SHALL make a read that follows a write to the same index return the newly written data.
REQ-025 On an accepted RDEX, RDL, WRC or BCST, SHALL drive SResp=ERR, SData=0 and SRespLast=1 for the next cycle, with no memory change.
REQ-026 SHALL drive SResp=NULL, SData=0 and SRespLast=0 in every cycle without a response.
REQ-027 In SRMD_RD, SHALL hold SCmdAccept=0 and ignore MCmd.

Reset
REQ-028 While MReset_n=0 at a rising edge, SHALL force state IDLE, SResp=NULL, SData=0, SRespLast=0 and clear the beat counter and burst address.
REQ-029 SHALL hold SCmdAccept=0 while MReset_n=0.
REQ-030 SHALL retain memory contents through reset; an in-flight burst SHALL be aborted and never resumed.

Configuration
REQ-031 Macro OCP_SLAVE_SRMD_EN defined: an accepted RD with MBurstSingleReq=1 SHALL latch index and MBurstLength, enter SRMD_RD, and emit DVA beats on consecutive cycles starting the next cycle.
REQ-032 With OCP_SLAVE_SRMD_EN, each SRMD beat SHALL increment the index by 1 modulo 2^MEM_DEPTH_LOG2 and SHALL assert SRespLast only on the final beat.
REQ-033 With OCP_SLAVE_SRMD_EN, MBurstLength=0 SHALL be treated as 1, and the block SHALL return to IDLE on the cycle after the final beat.
REQ-034 With OCP_SLAVE_SRMD_EN, an accepted write with MBurstSingleReq=1 SHALL receive an ERR response.
REQ-035 Macro OCP_SLAVE_SRMD_EN undefined: MBurstSingleReq SHALL be ignored, SRMD_RD SHALL be absent, and all reads SHALL follow REQ-022.

Verification
REQ-036 SHALL cover this case: WR addr 0x4, data 0xFF, then RD addr 0x4, MReqLast=1 -> SCmdAccept=1 on each command; the cycle after the RD gives SResp=DVA, SData=0xFF, SRespLast=1.
REQ-037 SHALL cover this case: 4-request RD burst at addrs 0x0/0x4/0x8/0xC, preloaded with 0x1..0x4, MReqLast on the 4th request -> 4 consecutive DVA beats with data 1,2,3,4, and SRespLast only on the 4th beat.
REQ-038 SHALL cover this case, with OCP_SLAVE_SRMD_EN: RD addr 0x38, MBurstLength=7, MBurstSingleReq=1 -> 7 DVA beats from indices 14,15,0,1,2,3,4 (wrap), SRespLast on beat 7, and SCmdAccept=0 throughout.
REQ-039 SHALL cover this case: MCmd=RDEX addr 0x0 -> SResp=ERR, SData=0, SRespLast=1 the next cycle, and memory unchanged on a later RD.
REQ-040 SHALL cover this case: MReset_n=0 during beat 3 of an SRMD burst of 7 -> all outputs 0/NULL at the next edge, IDLE after release, and the memory data still readable.
REQ-041 SHALL cover this case: WRNP addr 0x8, data 0x5A -> SResp=DVA the next cycle, and a later RD addr 0x8 returns 0x5A.
